// File: rtl/fa_checker_if.sv
// Stimulus/response and result bundle shared by the full-adder checker and its driver.
interface fa_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             vld;
  logic             a;
  logic             b;
  logic             C_in;
  logic             Sum;
  logic             C_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic             err_flag;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [7:0]       cov;
  logic [2:0]       first_err_vec;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output start, stop, vld, a, b, C_in, Sum, C_out,
    input  busy, done, pass, err_flag, vec_cnt, err_cnt, cov, first_err_vec, first_err_idx
  );

  modport slave (
    input  start, stop, vld, a, b, C_in, Sum, C_out,
    output busy, done, pass, err_flag, vec_cnt, err_cnt, cov, first_err_vec, first_err_idx
  );
endinterface

// File: rtl/fa_checker.sv
// Full-adder response checker: delays each stimulus vector by the expected DUT
// latency, compares the response against a reference adder, and accumulates
// counts, coverage and first-failure information for a pass/fail verdict.
module fa_checker #(
  parameter int EXP_LAT = 0,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  fa_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [1:0]       drain_left;
  logic             busy;
  logic             done;
  logic             pass;
  logic             err_flag;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [7:0]       cov;
  logic [2:0]       first_err_vec;
  logic [CNT_W-1:0] first_err_idx;

  logic             start_acc;
  logic             push_vld;
  logic [2:0]       push_vec;
  logic             chk_vld;
  logic [2:0]       chk_vec;
  logic             chk_fire;
  logic             exp_sum;
  logic             exp_cout;
  logic             mism;
  logic [CNT_W-1:0] vec_nxt;
  logic [CNT_W-1:0] err_nxt;
  logic [7:0]       cov_nxt;
  logic             run_pass;

  // A start is only honoured from IDLE or DONE; vectors are only taken in RUN.
  assign start_acc = bus.start && (state == IDLE || state == DONE);
  assign push_vld  = bus.vld && (state == RUN);
  assign push_vec  = {bus.a, bus.b, bus.C_in};

  generate
    if (EXP_LAT == 0) begin : g_nopipe
      assign chk_vld = push_vld;
      assign chk_vec = push_vec;
    end else begin : g_pipe
      logic [EXP_LAT-1:0] pipe_vld;
      logic [2:0]         pipe_vec [EXP_LAT];

      // Delay line matching the DUT latency; emptied on reset and on every new run.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_vld <= '0;
          for (int i = 0; i < EXP_LAT; i++) pipe_vec[i] <= 3'b000;
        end else if (start_acc) begin
          pipe_vld <= '0;
          for (int i = 0; i < EXP_LAT; i++) pipe_vec[i] <= 3'b000;
        end else begin
          pipe_vld[0] <= push_vld;
          pipe_vec[0] <= push_vec;
          for (int i = 1; i < EXP_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_vec[i] <= pipe_vec[i-1];
          end
        end
      end

      assign chk_vld = pipe_vld[EXP_LAT-1];
      assign chk_vec = pipe_vec[EXP_LAT-1];
    end
  endgenerate

  // Reference full adder evaluated on the delayed vector, compared to the live response.
  assign chk_fire = chk_vld && (state == RUN || state == DRAIN);
  assign exp_sum  = ^chk_vec;
  assign exp_cout = (chk_vec[2] & chk_vec[1]) | (chk_vec[2] & chk_vec[0]) | (chk_vec[1] & chk_vec[0]);
  assign mism     = chk_fire && ((bus.Sum != exp_sum) || (bus.C_out != exp_cout));

  // Next-cycle counter and coverage values, saturating rather than wrapping.
  always_comb begin
    vec_nxt = vec_cnt;
    err_nxt = err_cnt;
    cov_nxt = cov;
    if (chk_fire) begin
      if (vec_cnt != '1) vec_nxt = vec_cnt + 1'b1;
      cov_nxt = cov | (8'b1 << chk_vec);
      if (mism && err_cnt != '1) err_nxt = err_cnt + 1'b1;
    end
  end

  assign run_pass = (err_nxt == '0) && (cov_nxt == 8'hFF);

  // Run-control state machine with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      drain_left    <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_flag      <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      cov           <= 8'h00;
      first_err_vec <= 3'b000;
      first_err_idx <= '0;
    end else begin
      if (chk_fire) begin
        vec_cnt <= vec_nxt;
        err_cnt <= err_nxt;
        cov     <= cov_nxt;
        if (mism) begin
          err_flag <= 1'b1;
          if (!err_flag) begin
            first_err_vec <= chk_vec;
            first_err_idx <= vec_cnt;
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start_acc) begin
            state         <= RUN;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_flag      <= 1'b0;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            cov           <= 8'h00;
            first_err_vec <= 3'b000;
            first_err_idx <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            if (EXP_LAT == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= run_pass;
            end else begin
              state      <= DRAIN;
              drain_left <= 2'(EXP_LAT - 1);
            end
          end
        end
        DRAIN: begin
          if (drain_left == 2'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= run_pass;
          end else begin
            drain_left <= drain_left - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.pass          = pass;
  assign bus.err_flag      = err_flag;
  assign bus.vec_cnt       = vec_cnt;
  assign bus.err_cnt       = err_cnt;
  assign bus.cov           = cov;
  assign bus.first_err_vec = first_err_vec;
  assign bus.first_err_idx = first_err_idx;

endmodule
